alu_issue_station: RTL and testbench

// - Reservation station and issue scheduler for the combinational ALU.
// - Buffers dispatched ALU/branch ops, wakes operands from the CDB, picks one ready entry per cycle.
// - Drives the ALU's op/v1/v2/imm/pc/empty inputs from registers; the ALU result returns to the ROB by tag.

---
 rtl/alu_issue_station.sv | 151 +++++++++++++++
 tb/tb_alu_issue_station.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_station.sv
// Reservation station and issue scheduler for the combinational ALU.
// Buffers dispatched ops, wakes operands from the CDB, issues one ready entry per cycle.
module alu_issue_station #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_from_rob,
  input  logic              dispatch_valid,
  input  logic [OP_W-1:0]   dispatch_op,
  input  logic [DATA_W-1:0] dispatch_v1,
  input  logic [DATA_W-1:0] dispatch_v2,
  input  logic [TAG_W-1:0]  dispatch_q1,
  input  logic [TAG_W-1:0]  dispatch_q2,
  input  logic              dispatch_rdy1,
  input  logic              dispatch_rdy2,
  input  logic [DATA_W-1:0] dispatch_imm,
  input  logic [DATA_W-1:0] dispatch_pc,
  input  logic [TAG_W-1:0]  dispatch_tag,
  output logic              full_to_decoder,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [OP_W-1:0]   op_to_alu,
  output logic [DATA_W-1:0] v1_to_alu,
  output logic [DATA_W-1:0] v2_to_alu,
  output logic [DATA_W-1:0] imm_to_alu,
  output logic [DATA_W-1:0] pc_to_alu,
  output logic [TAG_W-1:0]  tag_to_rob,
  output logic              is_empty_to_alu
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  rdy1;
  logic [DEPTH-1:0]  rdy2;
  logic [OP_W-1:0]   e_op  [DEPTH];
  logic [DATA_W-1:0] e_v1  [DEPTH];
  logic [DATA_W-1:0] e_v2  [DEPTH];
  logic [TAG_W-1:0]  e_q1  [DEPTH];
  logic [TAG_W-1:0]  e_q2  [DEPTH];
  logic [DATA_W-1:0] e_imm [DEPTH];
  logic [DATA_W-1:0] e_pc  [DEPTH];
  logic [TAG_W-1:0]  e_tag [DEPTH];

  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic              free_found;
  logic              accept;
  logic              byp1;
  logic              byp2;

  assign full_to_decoder = &busy;
  assign accept          = dispatch_valid & ~full_to_decoder;
  assign byp1            = ~dispatch_rdy1 & cdb_valid & (cdb_tag == dispatch_q1);
  assign byp2            = ~dispatch_rdy2 & cdb_valid & (cdb_tag == dispatch_q2);

  // Both pickers look only at registered state, so a slot freed or woken at an edge
  // becomes visible to dispatch/select one cycle later.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    sel_idx    = '0;
    sel_found  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
      if (busy[i] && rdy1[i] && rdy2[i] && !sel_found) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy            <= '0;
      rdy1            <= '0;
      rdy2            <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_op[i]  <= '0;
        e_v1[i]  <= '0;
        e_v2[i]  <= '0;
        e_q1[i]  <= '0;
        e_q2[i]  <= '0;
        e_imm[i] <= '0;
        e_pc[i]  <= '0;
        e_tag[i] <= '0;
      end
      op_to_alu       <= '0;
      v1_to_alu       <= '0;
      v2_to_alu       <= '0;
      imm_to_alu      <= '0;
      pc_to_alu       <= '0;
      tag_to_rob      <= '0;
      is_empty_to_alu <= 1'b1;
    end else if (flush_from_rob) begin
      busy            <= '0;
      is_empty_to_alu <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy[i] && cdb_valid) begin
          if (!rdy1[i] && e_q1[i] == cdb_tag) begin
            e_v1[i] <= cdb_data;
            rdy1[i] <= 1'b1;
          end
          if (!rdy2[i] && e_q2[i] == cdb_tag) begin
            e_v2[i] <= cdb_data;
            rdy2[i] <= 1'b1;
          end
        end
      end

      if (sel_found) begin
        op_to_alu       <= e_op[sel_idx];
        v1_to_alu       <= e_v1[sel_idx];
        v2_to_alu       <= e_v2[sel_idx];
        imm_to_alu      <= e_imm[sel_idx];
        pc_to_alu       <= e_pc[sel_idx];
        tag_to_rob      <= e_tag[sel_idx];
        is_empty_to_alu <= 1'b0;
        busy[sel_idx]   <= 1'b0;
      end else begin
        is_empty_to_alu <= 1'b1;
      end

      // free_idx is never busy, so this cannot collide with the issue or wakeup writes.
      if (accept) begin
        busy[free_idx]  <= 1'b1;
        e_op[free_idx]  <= dispatch_op;
        e_v1[free_idx]  <= byp1 ? cdb_data : dispatch_v1;
        e_v2[free_idx]  <= byp2 ? cdb_data : dispatch_v2;
        e_q1[free_idx]  <= dispatch_q1;
        e_q2[free_idx]  <= dispatch_q2;
        rdy1[free_idx]  <= dispatch_rdy1 | byp1;
        rdy2[free_idx]  <= dispatch_rdy2 | byp2;
        e_imm[free_idx] <= dispatch_imm;
        e_pc[free_idx]  <= dispatch_pc;
        e_tag[free_idx] <= dispatch_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_station.sv
// Self-checking bench for alu_issue_station: directed scenarios feeding an issue scoreboard.
module tb_alu_issue_station;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  tag;
  } iss_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_from_rob;
  logic        dispatch_valid;
  logic [5:0]  dispatch_op;
  logic [31:0] dispatch_v1, dispatch_v2, dispatch_imm, dispatch_pc;
  logic [3:0]  dispatch_q1, dispatch_q2, dispatch_tag;
  logic        dispatch_rdy1, dispatch_rdy2;
  logic        full_to_decoder;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [5:0]  op_to_alu;
  logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
  logic [3:0]  tag_to_rob;
  logic        is_empty_to_alu;

  int   checks   = 0;
  int   failures = 0;
  iss_t sb[$];

  alu_issue_station #(.DEPTH(8), .OP_W(6), .DATA_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush_from_rob(flush_from_rob),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_v1(dispatch_v1), .dispatch_v2(dispatch_v2),
    .dispatch_q1(dispatch_q1), .dispatch_q2(dispatch_q2),
    .dispatch_rdy1(dispatch_rdy1), .dispatch_rdy2(dispatch_rdy2),
    .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc), .dispatch_tag(dispatch_tag),
    .full_to_decoder(full_to_decoder),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu), .tag_to_rob(tag_to_rob),
    .is_empty_to_alu(is_empty_to_alu)
  );

  always #5 clk = ~clk;

  // Every issued op must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && is_empty_to_alu === 1'b0) begin
      iss_t got;
      iss_t e;
      got = {op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu, tag_to_rob};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected got=%h required=none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL issue got=%h required=%h", got, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush_from_rob = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [3:0] q1, input logic [3:0] q2, input logic r1, input logic r2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    dispatch_valid = 1'b1;
    dispatch_op    = op;
    dispatch_v1    = v1;
    dispatch_v2    = v2;
    dispatch_q1    = q1;
    dispatch_q2    = q2;
    dispatch_rdy1  = r1;
    dispatch_rdy2  = r2;
    dispatch_imm   = imm;
    dispatch_pc    = pc;
    dispatch_tag   = tag;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick;
    tick;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain outstanding=%0d required=0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    checks++;
    if (is_empty_to_alu !== 1'b1 || full_to_decoder !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags empty=%b full=%b required empty=1 full=0", is_empty_to_alu, full_to_decoder);
    end
    checks++;
    if ({op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu, tag_to_rob} !== '0) begin
      failures++;
      $display("FAIL reset_outputs op=%h v1=%h tag=%h required=0", op_to_alu, v1_to_alu, tag_to_rob);
    end
    rst = 1'b1;
    tick;
    disp(6'h07, 32'h11, 32'h22, 4'd0, 4'd0, 1'b1, 1'b1, 32'h3, 32'h80, 4'd1);
    sb.push_back('{6'h07, 32'h11, 32'h22, 32'h3, 32'h80, 4'd1});
    tick;
    idle;
    wait_drain(5, "reset");
  endtask

  task automatic test_simple_issue;
    tick;
    disp(6'h01, 32'd5, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1, 32'h100, 32'h40, 4'd3);
    sb.push_back('{6'h01, 32'd5, 32'd7, 32'h100, 32'h40, 4'd3});
    tick;
    idle;
    checks++;
    if (is_empty_to_alu !== 1'b1) begin
      failures++;
      $display("FAIL simple_latency empty=%b required=1", is_empty_to_alu);
    end
    tick;
    checks++;
    if (is_empty_to_alu !== 1'b0 || op_to_alu !== 6'h01 || v1_to_alu !== 32'd5 ||
        v2_to_alu !== 32'd7 || tag_to_rob !== 4'd3) begin
      failures++;
      $display("FAIL simple_issue empty=%b op=%h v1=%0d v2=%0d tag=%0d required 0/01/5/7/3",
               is_empty_to_alu, op_to_alu, v1_to_alu, v2_to_alu, tag_to_rob);
    end
    tick;
    checks++;
    if (is_empty_to_alu !== 1'b1) begin
      failures++;
      $display("FAIL simple_after empty=%b required=1", is_empty_to_alu);
    end
  endtask

  task automatic test_wakeup;
    tick;
    disp(6'h02, 32'h0, 32'd9, 4'd2, 4'd0, 1'b0, 1'b1, 32'h4, 32'h44, 4'd5);
    sb.push_back('{6'h02, 32'h10, 32'd9, 32'h4, 32'h44, 4'd5});
    tick;
    idle;
    tick;
    cdb(4'd2, 32'h10);
    checks++;
    if (is_empty_to_alu !== 1'b1) begin
      failures++;
      $display("FAIL wakeup_wait empty=%b required=1", is_empty_to_alu);
    end
    tick;
    idle;
    checks++;
    if (is_empty_to_alu !== 1'b1) begin
      failures++;
      $display("FAIL wakeup_noearly empty=%b required=1", is_empty_to_alu);
    end
    tick;
    checks++;
    if (is_empty_to_alu !== 1'b0 || v1_to_alu !== 32'h10) begin
      failures++;
      $display("FAIL wakeup_issue empty=%b v1=%h required 0/10", is_empty_to_alu, v1_to_alu);
    end
    // Same-cycle CDB bypass at dispatch.
    tick;
    disp(6'h03, 32'h0, 32'd1, 4'd7, 4'd0, 1'b0, 1'b1, 32'h5, 32'h48, 4'd6);
    cdb(4'd7, 32'h22);
    sb.push_back('{6'h03, 32'h22, 32'd1, 32'h5, 32'h48, 4'd6});
    tick;
    idle;
    tick;
    checks++;
    if (is_empty_to_alu !== 1'b0 || v1_to_alu !== 32'h22) begin
      failures++;
      $display("FAIL bypass_issue empty=%b v1=%h required 0/22", is_empty_to_alu, v1_to_alu);
    end
    wait_drain(5, "wakeup");
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) begin
      tick;
      disp(6'h10 + 6'(i), 32'h0, 32'h200 + i, 4'(i), 4'd0, 1'b0, 1'b1, 32'(i), 32'h1000 + 4 * i, 4'(i + 8));
    end
    tick;
    checks++;
    if (full_to_decoder !== 1'b1) begin
      failures++;
      $display("FAIL full_set full=%b required=1", full_to_decoder);
    end
    disp(6'h3F, 32'h9, 32'h9, 4'd0, 4'd0, 1'b1, 1'b1, 32'h9, 32'h9, 4'd15);
    tick;
    idle;
    checks++;
    if (full_to_decoder !== 1'b1 || is_empty_to_alu !== 1'b1) begin
      failures++;
      $display("FAIL full_ignore full=%b empty=%b required 1/1", full_to_decoder, is_empty_to_alu);
    end
    cdb(4'd3, 32'hAB);
    sb.push_back('{6'h13, 32'hAB, 32'h203, 32'd3, 32'h100C, 4'd11});
    tick;
    idle;
    checks++;
    if (full_to_decoder !== 1'b1) begin
      failures++;
      $display("FAIL full_hold full=%b required=1", full_to_decoder);
    end
    tick;
    checks++;
    if (full_to_decoder !== 1'b0 || is_empty_to_alu !== 1'b0) begin
      failures++;
      $display("FAIL full_free full=%b empty=%b required 0/0", full_to_decoder, is_empty_to_alu);
    end
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        cdb(4'(i), 32'h100 + i);
        sb.push_back('{6'h10 + 6'(i), 32'h100 + i, 32'h200 + i, 32'(i), 32'h1000 + 4 * i, 4'(i + 8)});
        tick;
      end
    end
    idle;
    wait_drain(6, "full");
  endtask

  task automatic test_select_order;
    logic [3:0] qs [5];
    qs = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd11};
    for (int i = 0; i < 5; i++) begin
      tick;
      disp(6'h20 + 6'(i), 32'h0, 32'h30 + i, qs[i], 4'd0, 1'b0, 1'b1, 32'h40 + i, 32'h2000 + i, 4'(i + 1));
    end
    tick;
    idle;
    cdb(4'd11, 32'h77);
    sb.push_back('{6'h21, 32'h77, 32'h31, 32'h41, 32'h2001, 4'd2});
    sb.push_back('{6'h24, 32'h77, 32'h34, 32'h44, 32'h2004, 4'd5});
    tick;
    idle;
    tick;
    checks++;
    if (is_empty_to_alu !== 1'b0 || tag_to_rob !== 4'd2) begin
      failures++;
      $display("FAIL select_first empty=%b tag=%0d required 0/2", is_empty_to_alu, tag_to_rob);
    end
    tick;
    checks++;
    if (is_empty_to_alu !== 1'b0 || tag_to_rob !== 4'd5) begin
      failures++;
      $display("FAIL select_second empty=%b tag=%0d required 0/5", is_empty_to_alu, tag_to_rob);
    end
    for (int i = 0; i < 4; i++) begin
      if (i != 1) begin
        cdb(qs[i], 32'h500 + i);
        sb.push_back('{6'h20 + 6'(i), 32'h500 + i, 32'h30 + i, 32'h40 + i, 32'h2000 + i, 4'(i + 1)});
        tick;
      end
    end
    idle;
    wait_drain(5, "select");
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k >= 2) begin
        checks++;
        if (is_empty_to_alu !== 1'b0) begin
          failures++;
          $display("FAIL b2b_issue%0d empty=%b required=0", k - 2, is_empty_to_alu);
        end
      end
      disp(6'h30 + 6'(k), 32'h600 + k, 32'h700 + k, 4'd0, 4'd0, 1'b1, 1'b1, 32'h800 + k, 32'h3000 + k, 4'(k + 4));
      sb.push_back('{6'h30 + 6'(k), 32'h600 + k, 32'h700 + k, 32'h800 + k, 32'h3000 + k, 4'(k + 4)});
    end
    for (int k = 2; k < 4; k++) begin
      tick;
      idle;
      checks++;
      if (is_empty_to_alu !== 1'b0) begin
        failures++;
        $display("FAIL b2b_issue%0d empty=%b required=0", k, is_empty_to_alu);
      end
    end
    wait_drain(5, "b2b");
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) begin
      tick;
      disp(6'h38, 32'h0, 32'h1, 4'(i + 1), 4'd0, 1'b0, 1'b1, 32'h0, 32'h0, 4'(i));
    end
    tick;
    idle;
    flush_from_rob = 1'b1;
    disp(6'h3A, 32'h1, 32'h2, 4'd0, 4'd0, 1'b1, 1'b1, 32'h3, 32'h4, 4'd9);
    cdb(4'd1, 32'hDEAD);
    tick;
    idle;
    checks++;
    if (is_empty_to_alu !== 1'b1 || full_to_decoder !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear empty=%b full=%b required 1/0", is_empty_to_alu, full_to_decoder);
    end
    for (int i = 1; i <= 5; i++) begin
      cdb(4'(i), 32'hBAD0 + i);
      tick;
    end
    idle;
    tick;
    tick;
    disp(6'h0C, 32'h5A, 32'hA5, 4'd0, 4'd0, 1'b1, 1'b1, 32'h6, 32'h50, 4'd12);
    sb.push_back('{6'h0C, 32'h5A, 32'hA5, 32'h6, 32'h50, 4'd12});
    tick;
    idle;
    wait_drain(5, "flush");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8; i++) begin
      tick;
      disp(6'h11, 32'h0, 32'h0, 4'(i), 4'd0, 1'b0, 1'b1, 32'h0, 32'h0, 4'(i));
    end
    tick;
    idle;
    checks++;
    if (full_to_decoder !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_full full=%b required=1", full_to_decoder);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (is_empty_to_alu !== 1'b1 || full_to_decoder !== 1'b0 || op_to_alu !== 6'h0 || tag_to_rob !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_async empty=%b full=%b op=%h tag=%h required 1/0/00/0",
               is_empty_to_alu, full_to_decoder, op_to_alu, tag_to_rob);
    end
    tick;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cdb(4'(i), 32'hF00 + i);
      tick;
    end
    idle;
    tick;
    checks++;
    if (full_to_decoder !== 1'b0 || is_empty_to_alu !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_state full=%b empty=%b required 0/1", full_to_decoder, is_empty_to_alu);
    end
    disp(6'h2B, 32'h31, 32'h32, 4'd0, 4'd0, 1'b1, 1'b1, 32'h33, 32'h34, 4'd7);
    sb.push_back('{6'h2B, 32'h31, 32'h32, 32'h33, 32'h34, 4'd7});
    tick;
    idle;
    wait_drain(5, "rstmid");
  endtask

  initial begin
    rst = 1'b0;
    idle;
    dispatch_op = '0; dispatch_v1 = '0; dispatch_v2 = '0; dispatch_q1 = '0; dispatch_q2 = '0;
    dispatch_rdy1 = 1'b0; dispatch_rdy2 = 1'b0; dispatch_imm = '0; dispatch_pc = '0; dispatch_tag = '0;
    cdb_tag = '0; cdb_data = '0;
    #23;
    test_reset;
    test_simple_issue;
    test_wakeup;
    test_full;
    test_select_order;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    tick;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
